// File: rtl/hilo_muldiv_pkg.sv
// Shared constants, opcodes and FSM encoding for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    localparam int WIDTH = 32;              // operand / HI / LO width (only 32 supported)
    localparam int ITER  = 32;              // shift-add / restoring iterations, equals WIDTH
    localparam int CNT_W = $clog2(ITER);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    // Magnitude of a two's-complement value when the operation is signed.
    function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the execute stage and the HI/LO unit.
interface hilo_muldiv_if;
    import hilo_muldiv_pkg::*;

    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             op_ready;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side issues operations and reads HI/LO.
    modport master (
        output op_valid, op_code, op_a, op_b, flush,
        input  op_ready, busy, hi, lo
    );

    // Unit side.
    modport slave (
        input  op_valid, op_code, op_a, op_b, flush,
        output op_ready, busy, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_iter_dp.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on a
// combined 64-bit {upper, lower} accumulator. Both operations load {0, a}
// and keep b in a side register, so a single load path serves both.
module muldiv_iter_dp
    import hilo_muldiv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_count;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_acc_next;

    // Next accumulator value for one multiply or divide iteration.
    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        w_acc_next  = r_acc;
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff  = w_div_shift - {1'b0, r_b};
        if (i_div) begin
            // Top bit of the difference set means the trial subtraction borrowed.
            if (w_div_diff[WIDTH])
                w_acc_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            else
                w_acc_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Accumulator, divisor/multiplicand and iteration counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_acc   <= '0;
            r_b     <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_acc   <= {{WIDTH{1'b0}}, i_a};
            r_b     <= i_b;
            r_count <= '0;
        end else if (i_step) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_count == CNT_W'(ITER - 1));

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative MULT/MULTU/DIV/DIVU engine.
// Sequence IDLE -> MUL|DIV (32 edges) -> FIX (1 edge) -> IDLE gives a
// constant 33-cycle busy window. WIDTH/ITER are fixed at 32 in the package.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);

    state_e r_state, w_state_next;

    logic             r_is_div, r_neg_q, r_neg_r, r_div0;
    logic [WIDTH-1:0] r_a_raw, r_hi, r_lo;

    logic               w_accept, w_start_mul, w_start_div, w_signed;
    logic               w_load, w_step, w_last;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q_fix, w_r_fix;
    logic [2*WIDTH-1:0] w_acc, w_prod_fix;

    assign w_accept    = bus.op_valid && (r_state == S_IDLE) && !bus.flush;
    assign w_start_mul = w_accept && (bus.op_code == OP_MULT || bus.op_code == OP_MULTU);
    assign w_start_div = w_accept && (bus.op_code == OP_DIV  || bus.op_code == OP_DIVU);
    assign w_signed    = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
    assign w_abs_a     = abs_if(bus.op_a, w_signed);
    assign w_abs_b     = abs_if(bus.op_b, w_signed);

    muldiv_iter_dp u_dp (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_div  (r_state == S_DIV),
        .i_a    (w_abs_a),
        .i_b    (w_abs_b),
        .o_acc  (w_acc),
        .o_last (w_last)
    );

    // State register; reset takes priority over flush.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:       if (w_start_mul)      w_state_next = S_MUL;
                              else if (w_start_div) w_state_next = S_DIV;
                S_MUL, S_DIV: if (w_last)           w_state_next = S_FIX;
                S_FIX:        w_state_next = S_IDLE;
                default:      w_state_next = S_IDLE;
            endcase
        end
    end

    // Status outputs and datapath strobes decoded from the state.
    always_comb begin
        bus.busy     = (r_state != S_IDLE);
        bus.op_ready = (r_state == S_IDLE);
        w_load       = w_start_mul || w_start_div;
        w_step       = (r_state == S_MUL || r_state == S_DIV) && !bus.flush;
    end

    // Result sign flags and divide-by-zero capture at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a_raw  <= '0;
        end else if (w_load) begin
            r_is_div <= w_start_div;
            r_neg_q  <= w_signed && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            r_neg_r  <= w_signed && bus.op_a[WIDTH-1];
            r_div0   <= w_start_div && (bus.op_b == '0);
            r_a_raw  <= bus.op_a;
        end
    end

    // Sign correction applied to the unsigned magnitude result in FIX.
    always_comb begin
        w_prod_fix = r_neg_q ? -w_acc : w_acc;
        w_q_fix    = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
        w_r_fix    = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    end

    // HI/LO update: FIX writes the result, MTHI/MTLO write at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_FIX && !bus.flush) begin
            if (r_is_div && r_div0) begin
                r_hi <= r_a_raw;
                r_lo <= '1;
            end else if (r_is_div) begin
                r_hi <= w_r_fix;
                r_lo <= w_q_fix;
            end else begin
                {r_hi, r_lo} <= w_prod_fix;
            end
        end else if (w_accept && bus.op_code == OP_MTHI) begin
            r_hi <= bus.op_a;
        end else if (w_accept && bus.op_code == OP_MTLO) begin
            r_lo <= bus.op_a;
        end
    end

    assign bus.hi = r_hi;
    assign bus.lo = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus random operations
// compared against an arithmetic reference of the HI/LO results.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    hilo_muldiv_if bus ();

    hilo_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] m_hilo;        // reference {hi, lo}
    logic [63:0] saved;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural HI/LO result from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        int q, r;
        case (op)
            OP_MULT:  return 64'(longint'($signed(a)) * longint'($signed(b)));
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_MTHI: return {a, cur[31:0]};
            OP_MTLO: return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    task automatic drive_idle();
        bus.op_valid = 1'b0;
        bus.op_code  = OP_NOP;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.flush    = 1'b0;
    endtask

    // Issue one op at a negedge, then measure busy length and check HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int   n;
        logic rdy_bad;
        n = 0;
        while (!bus.op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, bus.op_ready, 1);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.op_a     = a;
        bus.op_b     = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        m_hilo = ref_result(op, a, b, m_hilo);
        n = 0;
        rdy_bad = 1'b0;
        while (bus.busy && n < 100) begin
            if (bus.op_ready) rdy_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, n, (op >= OP_MULT && op <= OP_DIVU) ? 33 : 0);
        check({tag, "_ready_low"}, rdy_bad, 0);
        check({tag, "_hi"}, bus.hi, m_hilo[63:32]);
        check({tag, "_lo"}, bus.lo, m_hilo[31:0]);
    endtask

    initial begin
        int          n;
        logic [2:0]  op;
        logic [31:0] a, b;

        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_hilo = '0;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.op_ready, 1);

        // Signed and unsigned multiply.
        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_k", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_k", bus.lo, 32'hFFFF_FFFA);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi_k", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo_k", bus.lo, 32'h0000_0001);

        // Divides, divide by zero and the signed overflow case.
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_k", bus.lo, 32'hFFFF_FFFD);
        check("div_hi_k", bus.hi, 32'hFFFF_FFFF);
        run_op("divu", OP_DIVU, 32'd7, 32'd2);
        check("divu_lo_k", bus.lo, 32'd3);
        check("divu_hi_k", bus.hi, 32'd1);
        run_op("divu0", OP_DIVU, 32'd5, 32'd0);
        check("divu0_lo_k", bus.lo, 32'hFFFF_FFFF);
        check("divu0_hi_k", bus.hi, 32'd5);
        run_op("div0s", OP_DIV, 32'hFFFF_FFF0, 32'd0);
        run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo_k", bus.lo, 32'h8000_0000);
        check("divovf_hi_k", bus.hi, 32'h0);

        // MTHI then MTLO on consecutive edges.
        bus.op_valid = 1'b1;
        bus.op_code  = OP_MTHI;
        bus.op_a     = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_busy", bus.busy, 0);
        bus.op_code = OP_MTLO;
        bus.op_a    = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.op_valid = 1'b0;
        check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
        check("mtlo_hi", bus.hi, 32'h1234_5678);
        check("mtlo_busy", bus.busy, 0);
        m_hilo = {32'h1234_5678, 32'h9ABC_DEF0};

        // MULT held valid while a DIVU is in flight.
        bus.op_valid = 1'b1;
        bus.op_code  = OP_DIVU;
        bus.op_a     = 32'd100;
        bus.op_b     = 32'd7;
        @(negedge clk);
        m_hilo = ref_result(OP_DIVU, 32'd100, 32'd7, m_hilo);
        bus.op_code = OP_MULT;
        bus.op_a    = 32'hFFFF_1234;
        bus.op_b    = 32'h0000_5678;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("held_first_lat", n, 33);
        check("held_first_hi", bus.hi, m_hilo[63:32]);
        check("held_first_lo", bus.lo, m_hilo[31:0]);
        @(negedge clk);
        check("held_accept", bus.busy, 1);
        bus.op_valid = 1'b0;
        m_hilo = ref_result(OP_MULT, 32'hFFFF_1234, 32'h0000_5678, m_hilo);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("held_mult_lat", n, 33);
        check("held_mult_hi", bus.hi, m_hilo[63:32]);
        check("held_mult_lo", bus.lo, m_hilo[31:0]);

        // Flush in the tenth busy cycle of a DIV.
        saved = m_hilo;
        bus.op_valid = 1'b1;
        bus.op_code  = OP_DIV;
        bus.op_a     = 32'd1000;
        bus.op_b     = 32'd3;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_hilo", {bus.hi, bus.lo}, saved);
        repeat (40) @(negedge clk);
        check("flush_hilo_later", {bus.hi, bus.lo}, saved);

        // Flush beats an MTHI in IDLE; unknown opcode is a NOP.
        bus.op_valid = 1'b1;
        bus.op_code  = OP_MTHI;
        bus.op_a     = 32'hDEAD_BEEF;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.flush   = 1'b0;
        bus.op_code = 3'd7;
        @(negedge clk);
        bus.op_valid = 1'b0;
        check("flush_mthi_hi", bus.hi, saved[63:32]);
        check("unknown_op", {bus.hi, bus.lo}, saved);
        check("unknown_busy", bus.busy, 0);

        // Reset in the middle of a MULT.
        bus.op_valid = 1'b1;
        bus.op_code  = OP_MULT;
        bus.op_a     = 32'h0001_0001;
        bus.op_b     = 32'h0000_0010;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hilo = '0;
        check("rst_mid_hilo", {bus.hi, bus.lo}, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_ready", bus.op_ready, 1);
        repeat (40) @(negedge clk);
        check("rst_mid_later", {bus.hi, bus.lo}, 0);

        // Random operations against the reference.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), op, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
